// File: rtl/fetch_queue_pkg.sv
//------------------------------------------------------------------------------
// Module   : fv_pkg
// Purpose  : Shared types and constants for the fetch queue slice.
//            XLEN      - width of instruction and PC fields
//            NOP_INST  - instruction presented to ID when the queue is empty
//            fetch_pkt_t - one queued fetch {inst, pc, pc_n}
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
  } fetch_pkt_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_queue_if
// Purpose  : IF-side and ID-side signal bundle of the fetch queue.
//            IF side : if_valid, if_inst, if_pc, if_pc_n, flush -> queue
//                      pc_en                                     <- queue
//            ID side : id_ready                                  -> queue
//                      id_valid, id_inst, id_pc, id_pc_n         <- queue
//            Status  : occupancy                                 <- queue
//            Modports: master (pipeline side driving the queue),
//                      slave  (the queue itself).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_queue_if #(
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                       if_valid;
  logic [fv_pkg::XLEN-1:0]    if_inst;
  logic [fv_pkg::XLEN-1:0]    if_pc;
  logic [fv_pkg::XLEN-1:0]    if_pc_n;
  logic                       flush;
  logic                       pc_en;
  logic                       id_ready;
  logic                       id_valid;
  logic [fv_pkg::XLEN-1:0]    id_inst;
  logic [fv_pkg::XLEN-1:0]    id_pc;
  logic [fv_pkg::XLEN-1:0]    id_pc_n;
  logic [CNT_W-1:0]           occupancy;

  modport master (
    output if_valid, if_inst, if_pc, if_pc_n, flush, id_ready,
    input  pc_en, id_valid, id_inst, id_pc, id_pc_n, occupancy
  );

  modport slave (
    input  if_valid, if_inst, if_pc, if_pc_n, flush, id_ready,
    output pc_en, id_valid, id_inst, id_pc, id_pc_n, occupancy
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue_storage.sv
//------------------------------------------------------------------------------
// Module   : fq_storage
// Purpose  : DEPTH-entry register array of fetch packets.
//            clk     - write clock
//            i_we    - write enable
//            i_waddr - write index (tail)
//            i_wdata - packet to write
//            i_raddr - read index (head), read is asynchronous
//            o_rdata - packet at i_raddr
//            Contents are not reset; validity is tracked by the owner.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fq_storage
  import fv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [PTR_W-1:0] i_waddr,
  input  wire fetch_pkt_t       i_wdata,
  input  wire logic [PTR_W-1:0] i_raddr,
  output fetch_pkt_t            o_rdata
);

  fetch_pkt_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module   : fetch_queue
// Purpose  : Instruction buffer between IF and ID. Captures {inst, pc, pc+4}
//            on every accepted IF fetch, presents the oldest entry to ID with
//            a valid/ready handshake, stalls IF only when a valid fetch
//            cannot be accepted, and empties on a redirect (flush).
//            clk - clock, rising edge
//            rst - synchronous active-high reset
//            bus - fetch_queue_if.slave (IF side, ID side, occupancy)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic       w_id_valid;
  logic       w_pop;
  logic       w_can_push;
  logic       w_push;
  fetch_pkt_t w_wdata;
  fetch_pkt_t w_head_pkt;

  assign w_id_valid = (r_count != '0);
  assign w_pop      = w_id_valid & bus.id_ready;
  // A full queue can still take a fetch when the head leaves in the same cycle.
  assign w_can_push = (r_count < C_DEPTH) | w_pop;
  assign w_push     = bus.if_valid & w_can_push & ~bus.flush;

  // IF holds its PC only when it has a valid fetch the queue cannot take;
  // a redirect always lets IF load the branch target.
  assign bus.pc_en  = bus.flush | (bus.if_valid & w_can_push) | ~bus.if_valid;

  assign w_wdata.inst = bus.if_inst;
  assign w_wdata.pc   = bus.if_pc;
  assign w_wdata.pc_n = bus.if_pc_n;

  fq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_push & ~rst),
    .i_waddr (r_tail),
    .i_wdata (w_wdata),
    .i_raddr (r_head),
    .o_rdata (w_head_pkt)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + C_PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared, so stale data is masked while empty.
  assign bus.id_valid  = w_id_valid;
  assign bus.id_inst   = w_id_valid ? w_head_pkt.inst : NOP_INST;
  assign bus.id_pc     = w_id_valid ? w_head_pkt.pc   : '0;
  assign bus.id_pc_n   = w_id_valid ? w_head_pkt.pc_n : '0;
  assign bus.occupancy = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue (DEPTH=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;
  import fv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic fl, input logic rdy);
    bus.if_valid = v;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    bus.if_pc_n  = pc + 32'd4;
    bus.flush    = fl;
    bus.id_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid got=%0b exp=0", bus.id_valid); end
    total++; if (bus.id_inst !== 32'h0000_0013) begin bad++; $display("FAIL rst_id_inst got=%h exp=00000013", bus.id_inst); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", bus.occupancy); end
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL rst_pc_en got=%0b exp=1", bus.pc_en); end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    total++; if (bus.id_valid !== 1'b0 || bus.occupancy !== 3'd0) begin bad++; $display("FAIL post_rst_empty got v=%0b occ=%0d exp v=0 occ=0", bus.id_valid, bus.occupancy); end
  endtask

  task automatic test_pass_through();
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b1);
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL pass_no_bypass got=%0b exp=0", bus.id_valid); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.id_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%0b exp=1", bus.id_valid); end
    total++; if (bus.id_inst !== 32'h0050_0093) begin bad++; $display("FAIL pass_inst got=%h exp=00500093", bus.id_inst); end
    total++; if (bus.id_pc !== 32'h100 || bus.id_pc_n !== 32'h104) begin bad++; $display("FAIL pass_pc got=%h/%h exp=100/104", bus.id_pc, bus.id_pc_n); end
    tick();
    total++; if (bus.id_valid !== 1'b0 || bus.occupancy !== 3'd0) begin bad++; $display("FAIL pass_drained got v=%0b occ=%0d exp v=0 occ=0", bus.id_valid, bus.occupancy); end
    total++; if (bus.id_pc !== 32'h0) begin bad++; $display("FAIL pass_empty_pc got=%h exp=0", bus.id_pc); end
  endtask

  task automatic test_fill_stall();
    logic [2:0] exp_occ [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic       exp_en  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hA000_0000 + i, 32'(4 * i), 1'b0, 1'b0);
      total++; if (bus.pc_en !== exp_en[i]) begin bad++; $display("FAIL fill_pc_en[%0d] got=%0b exp=%0b", i, bus.pc_en, exp_en[i]); end
      tick();
      total++; if (bus.occupancy !== exp_occ[i]) begin bad++; $display("FAIL fill_occ[%0d] got=%0d exp=%0d", i, bus.occupancy, exp_occ[i]); end
      total++; if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'hA000_0000) begin bad++; $display("FAIL fill_head[%0d] got pc=%h inst=%h exp pc=0 inst=a0000000", i, bus.id_pc, bus.id_inst); end
    end
  endtask

  // Starts full with pc 0,4,8,C; each cycle pops the head and pushes a new one.
  task automatic test_full_push_pop();
    logic [31:0] exp_pc [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hB000_0000 + i, 32'h10 + 32'(4 * i), 1'b0, 1'b1);
      total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL full_pc_en[%0d] got=%0b exp=1", i, bus.pc_en); end
      total++; if (bus.id_pc !== exp_pc[i] || bus.id_pc_n !== exp_pc[i] + 32'd4) begin bad++; $display("FAIL full_head_pc[%0d] got=%h exp=%h", i, bus.id_pc, exp_pc[i]); end
      tick();
      total++; if (bus.occupancy !== 3'd4) begin bad++; $display("FAIL full_occ[%0d] got=%0d exp=4", i, bus.occupancy); end
    end
    for (int i = 6; i < 10; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      total++; if (bus.id_pc !== exp_pc[i] || bus.id_inst !== 32'hB000_0000 + 32'(i - 4)) begin bad++; $display("FAIL drain_head[%0d] got pc=%h inst=%h exp pc=%h", i, bus.id_pc, bus.id_inst, exp_pc[i]); end
      tick();
    end
    total++; if (bus.occupancy !== 3'd0 || bus.id_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got occ=%0d v=%0b exp occ=0 v=0", bus.occupancy, bus.id_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC000_0000 + i, 32'h40 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    total++; if (bus.occupancy !== 3'd3) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=3", bus.occupancy); end
    drive(1'b1, 32'hCCCC_0000, 32'h20, 1'b1, 1'b1);
    total++; if (bus.pc_en !== 1'b1) begin bad++; $display("FAIL flush_pc_en got=%0b exp=1", bus.pc_en); end
    total++; if (bus.id_pc !== 32'h40) begin bad++; $display("FAIL flush_pop_head got=%h exp=40", bus.id_pc); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.occupancy !== 3'd0 || bus.id_valid !== 1'b0 || bus.id_pc === 32'h20) begin bad++; $display("FAIL flush_empty[%0d] got occ=%0d v=%0b pc=%h exp occ=0 v=0", i, bus.occupancy, bus.id_valid, bus.id_pc); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hD000_0000 + i, 32'h60 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    total++; if (bus.occupancy !== 3'd2) begin bad++; $display("FAIL rmid_pre_occ got=%0d exp=2", bus.occupancy); end
    rst = 1'b1;
    drive(1'b1, 32'hD000_0002, 32'h68, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    total++; if (bus.occupancy !== 3'd0 || bus.id_valid !== 1'b0) begin bad++; $display("FAIL rmid_empty got occ=%0d v=%0b exp occ=0 v=0", bus.occupancy, bus.id_valid); end
    drive(1'b1, 32'hE000_0000, 32'h70, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    total++; if (bus.occupancy !== 3'd1 || bus.id_pc !== 32'h70 || bus.id_inst !== 32'hE000_0000) begin bad++; $display("FAIL rmid_first got occ=%0d pc=%h inst=%h exp occ=1 pc=70 inst=e0000000", bus.occupancy, bus.id_pc, bus.id_inst); end
    tick();
    total++; if (bus.occupancy !== 3'd0 || bus.id_valid !== 1'b0) begin bad++; $display("FAIL rmid_alone got occ=%0d v=%0b exp occ=0 v=0", bus.occupancy, bus.id_valid); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_fill_stall();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the IF stage and the ID stage.
- Captures {inst, pc, pc+4} from IF whenever IF presents a valid fetch, and holds up to DEPTH entries.
- Presents the oldest entry to ID with a valid/ready handshake.
- Drives IF's pc_en so that fetch stalls only when the queue cannot accept.
- Flushes all entries on a redirect so the IF mux can load the branch target.

Parameters:
- XLEN, 32: width of instruction and PC fields.
- DEPTH, 4: number of entries. Must be a power of 2 and ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  IF presents a fetched instruction this cycle.
- if_inst  in  XLEN  instruction from IF inst_out.
- if_pc  in  XLEN  PC of the instruction (IF pc_p).
- if_pc_n  in  XLEN  pc+4 from IF (pc_n).
- flush  in  1  redirect; same signal as IF branch_sel.
- pc_en  out  1  to IF pc_en; 1 means IF's PC register updates this edge.
- id_ready  in  1  ID accepts the head entry this cycle.
- id_valid  out  1  head entry is valid.
- id_inst  out  XLEN  head instruction.
- id_pc  out  XLEN  head PC.
- id_pc_n  out  XLEN  head pc+4.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Priority each edge: rst > flush > push/pop.
- pop = id_valid & id_ready.
- can_push = (occupancy < DEPTH) | pop.
- push = if_valid & can_push & ~flush.
- pc_en = flush | (if_valid & can_push) | ~if_valid. Combinational. IF holds its PC exactly when a valid fetch cannot be accepted.
- Push writes {if_inst, if_pc, if_pc_n} at the tail; the tail pointer increments mod DEPTH.
- Pop increments the head pointer mod DEPTH.
- occupancy counter:
  - +1 on push only
  - −1 on pop only
  - unchanged on push+pop
- Latency: an entry pushed at edge k is visible on id_* in cycle k+1. There is no same-cycle bypass when empty.
- id_valid = (occupancy != 0).
- When id_valid=0:
  - id_inst = NOP_INST (32'h0000_0013)
  - id_pc = 0
  - id_pc_n = 0
- Full (occupancy==DEPTH):
  - without pop: push refused and pc_en=0 when if_valid=1.
  - with pop: push accepted and occupancy stays DEPTH.
- Empty: pop cannot occur because id_valid=0.
- Pointers wrap from DEPTH−1 to 0 with no skipped or duplicated entries.
- flush:
  - next state is head=tail=0, occupancy=0.
  - the instruction presented in the flush cycle is dropped (wrong path).
  - any pop in the same cycle completes at the ID side, but the queue still empties.
  - pc_en=1 so IF loads the branch target.
- Reset, including mid-operation:
  - head, tail and occupancy set to 0.
  - id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc_n=0.
  - storage contents need not be cleared.
  - pc_en follows the combinational rule with occupancy=0.
- The queue performs no arithmetic on data fields; pc fields pass through unchanged.

Decomposition:
- Shared package fv_pkg:
  - XLEN
  - NOP_INST
  - typedef struct packed fetch_pkt_t {inst, pc, pc_n}
- Sub-module fq_storage: DEPTH×fetch_pkt_t register array with one synchronous write port and one asynchronous read port at the head.
- Pointer, counter and handshake logic stay in fetch_queue.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles with if_valid=1, if_inst=32'hDEAD_BEEF.
  - Response: id_valid=0, id_inst=32'h0000_0013, occupancy=0, and the queue is empty the cycle after rst drops.
- Single pass-through:
  - Stimulus: one push of inst=32'h0050_0093, pc=0x100, pc_n=0x104, with id_ready=1.
  - Response: id_valid=1 for exactly one cycle after the push, id_* matching, then occupancy=0.
- Fill and stall:
  - Stimulus: id_ready=0, if_valid=1 for 6 cycles, pc=0x0,0x4,…
  - Response: occupancy 1,2,3,4,4,4; pc_en=0 from the 5th cycle; id_pc stays 0x0.
- Full with simultaneous push/pop:
  - Stimulus: full queue, id_ready=1, if_valid=1.
  - Response: occupancy stays 4, pc_en=1, id_pc steps 0x0→0x4→0x8, and a push written at tail index 3 wraps the next write to index 0 in order.
- Flush:
  - Stimulus: 3 entries queued, flush=1 with if_valid=1, if_pc=0x20.
  - Response: next cycle occupancy=0, id_valid=0, pc_en=1 during flush, and 0x20 is never presented to ID.
- Reset mid-stream:
  - Stimulus: 2 entries queued, rst pulsed during a push+pop cycle.
  - Response: occupancy=0 and id_valid=0 the next cycle; the first post-reset push appears alone.
